// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory request/response interface between
// the I-cache refill path (port 0) and the D-cache refill/writeback path
// (port 1). Whole transactions are granted round-robin; the request and any
// write-data beats come from the winner, and responses are steered back by
// the external tag MSB.
module mem_arbiter #(
    parameter int ADDR_BITS   = 28,
    parameter int TAG_BITS    = 5,
    parameter int DATA_BITS   = 128,
    parameter int DATA_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     p0_req_valid,
    output logic                     p0_req_ready,
    input  logic                     p0_req_rw,
    input  logic [ADDR_BITS-1:0]     p0_req_addr,
    input  logic [TAG_BITS-2:0]      p0_req_tag,
    input  logic                     p0_data_valid,
    output logic                     p0_data_ready,
    input  logic [DATA_BITS-1:0]     p0_data_bits,
    input  logic [DATA_BITS/8-1:0]   p0_data_mask,
    output logic                     p0_resp_valid,
    output logic [TAG_BITS-2:0]      p0_resp_tag,
    output logic [DATA_BITS-1:0]     p0_resp_data,

    input  logic                     p1_req_valid,
    output logic                     p1_req_ready,
    input  logic                     p1_req_rw,
    input  logic [ADDR_BITS-1:0]     p1_req_addr,
    input  logic [TAG_BITS-2:0]      p1_req_tag,
    input  logic                     p1_data_valid,
    output logic                     p1_data_ready,
    input  logic [DATA_BITS-1:0]     p1_data_bits,
    input  logic [DATA_BITS/8-1:0]   p1_data_mask,
    output logic                     p1_resp_valid,
    output logic [TAG_BITS-2:0]      p1_resp_tag,
    output logic [DATA_BITS-1:0]     p1_resp_data,

    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_rw,
    output logic [ADDR_BITS-1:0]     mem_req_addr,
    output logic [TAG_BITS-1:0]      mem_req_tag,
    output logic                     mem_req_data_valid,
    input  logic                     mem_req_data_ready,
    output logic [DATA_BITS-1:0]     mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]   mem_req_data_mask,

    input  logic                     mem_resp_valid,
    input  logic [TAG_BITS-1:0]      mem_resp_tag,
    input  logic [DATA_BITS-1:0]     mem_resp_data
);
    localparam int CNT_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WDATA = 2'd2
    } state_t;

    state_t             state;
    logic               grant;
    logic               last;
    logic [CNT_W-1:0]   beat_cnt;

    logic               in_grant;
    logic               in_wdata;
    logic               sel_req_valid;
    logic               sel_req_rw;
    logic               sel_data_valid;
    logic               req_fire;
    logic               data_fire;

    assign in_grant       = (state == GRANT);
    assign in_wdata       = (state == WDATA);
    assign sel_req_valid  = grant ? p1_req_valid  : p0_req_valid;
    assign sel_req_rw     = grant ? p1_req_rw     : p0_req_rw;
    assign sel_data_valid = grant ? p1_data_valid : p0_data_valid;
    assign req_fire       = in_grant & sel_req_valid & mem_req_ready;
    assign data_fire      = in_wdata & sel_data_valid & mem_req_data_ready;

    // Transaction sequencing: pick a winner in IDLE, hold it through the
    // request handshake and, for writes, through every data beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 1'b0;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req_valid || p1_req_valid) begin
                        // A tie goes to the port that was not granted last.
                        grant <= (p0_req_valid && p1_req_valid) ? ~last : p1_req_valid;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (req_fire) begin
                        last     <= grant;
                        beat_cnt <= '0;
                        state    <= sel_req_rw ? WDATA : IDLE;
                    end
                end
                WDATA: begin
                    if (data_fire) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request channel: only the granted port sees ready, only in GRANT.
    assign mem_req_valid = in_grant & sel_req_valid;
    assign mem_req_rw    = sel_req_rw;
    assign mem_req_addr  = grant ? p1_req_addr : p0_req_addr;
    assign mem_req_tag   = {grant, (grant ? p1_req_tag : p0_req_tag)};
    assign p0_req_ready  = in_grant & ~grant & mem_req_ready;
    assign p1_req_ready  = in_grant &  grant & mem_req_ready;

    // Write-data channel: open only to the granted port while in WDATA.
    assign mem_req_data_valid = in_wdata & sel_data_valid;
    assign mem_req_data_bits  = grant ? p1_data_bits : p0_data_bits;
    assign mem_req_data_mask  = grant ? p1_data_mask : p0_data_mask;
    assign p0_data_ready      = in_wdata & ~grant & mem_req_data_ready;
    assign p1_data_ready      = in_wdata &  grant & mem_req_data_ready;

    // Response steering is stateless: the tag MSB names the owner.
    assign p0_resp_valid = mem_resp_valid & ~mem_resp_tag[TAG_BITS-1];
    assign p1_resp_valid = mem_resp_valid &  mem_resp_tag[TAG_BITS-1];
    assign p0_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    assign p1_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    assign p0_resp_data  = mem_resp_data;
    assign p1_resp_data  = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level model of bus ownership.
module tb_mem_arbiter;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic         req_valid [2];
    logic         req_ready [2];
    logic         req_rw    [2];
    logic [27:0]  req_addr  [2];
    logic [3:0]   req_tag   [2];
    logic         data_valid[2];
    logic         data_ready[2];
    logic [127:0] data_bits [2];
    logic [15:0]  data_mask [2];
    logic         resp_valid[2];
    logic [3:0]   resp_tag  [2];
    logic [127:0] resp_data [2];

    logic         mem_req_valid, mem_req_ready, mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [4:0]   mem_req_tag;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [4:0]   mem_resp_tag;
    logic [127:0] mem_resp_data;

    int tests = 0;
    int errs  = 0;

    bit rand_mem  = 0;
    bit rand_resp = 0;
    bit tog_dr    = 0;

    // Beats each requester will send for its current write.
    logic [127:0] wb [2][4];
    logic [15:0]  wm [2][4];

    // Model state: who owns the bus and which beats are still owed.
    int           m_phase = 0;   // 0 free, 1 request owned, 2 data owed
    int           m_own   = 0;
    bit           m_last  = 1'b1;
    bit           rst_prev = 1'b1;
    logic [127:0] eb[$];
    logic [15:0]  em[$];
    int           glog[$];
    logic [127:0] blog[$];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(req_valid[0]), .p0_req_ready(req_ready[0]), .p0_req_rw(req_rw[0]),
        .p0_req_addr(req_addr[0]), .p0_req_tag(req_tag[0]),
        .p0_data_valid(data_valid[0]), .p0_data_ready(data_ready[0]),
        .p0_data_bits(data_bits[0]), .p0_data_mask(data_mask[0]),
        .p0_resp_valid(resp_valid[0]), .p0_resp_tag(resp_tag[0]), .p0_resp_data(resp_data[0]),
        .p1_req_valid(req_valid[1]), .p1_req_ready(req_ready[1]), .p1_req_rw(req_rw[1]),
        .p1_req_addr(req_addr[1]), .p1_req_tag(req_tag[1]),
        .p1_data_valid(data_valid[1]), .p1_data_ready(data_ready[1]),
        .p1_data_bits(data_bits[1]), .p1_data_mask(data_mask[1]),
        .p1_resp_valid(resp_valid[1]), .p1_resp_tag(resp_tag[1]), .p1_resp_data(resp_data[1]),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory-side stimulus: random readiness and random responses when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_mem) begin
            mem_req_ready      = ($urandom % 3) != 0;
            mem_req_data_ready = ($urandom % 3) != 0;
        end else if (tog_dr) begin
            mem_req_data_ready = ~mem_req_data_ready;
        end
        if (rand_resp) begin
            mem_resp_valid = $urandom % 2;
            mem_resp_tag   = 5'($urandom);
            mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Reference model and per-cycle comparison.
    always @(negedge clk) begin
        int o;
        if (rst_prev) begin
            m_phase = 0;
            m_last  = 1'b1;
            eb.delete();
            em.delete();
        end
        chk("resp_valid0", resp_valid[0], mem_resp_valid && !mem_resp_tag[4]);
        chk("resp_valid1", resp_valid[1], mem_resp_valid &&  mem_resp_tag[4]);
        chk("resp_tag0", resp_tag[0], mem_resp_tag[3:0]);
        chk("resp_tag1", resp_tag[1], mem_resp_tag[3:0]);
        chk("resp_data0", resp_data[0], mem_resp_data);
        chk("resp_data1", resp_data[1], mem_resp_data);
        o = m_own;
        if (m_phase == 0) begin
            chk("free_req_valid", mem_req_valid, 0);
            chk("free_req_ready0", req_ready[0], 0);
            chk("free_req_ready1", req_ready[1], 0);
            chk("free_data_valid", mem_req_data_valid, 0);
            chk("free_data_ready0", data_ready[0], 0);
            chk("free_data_ready1", data_ready[1], 0);
            if (!reset && (req_valid[0] || req_valid[1])) begin
                m_own   = (req_valid[0] && req_valid[1]) ? int'(!m_last) : (req_valid[1] ? 1 : 0);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            chk("req_valid", mem_req_valid, req_valid[o]);
            chk("req_ready_owner", req_ready[o], mem_req_ready);
            chk("req_ready_other", req_ready[1-o], 0);
            chk("req_data_valid", mem_req_data_valid, 0);
            chk("req_data_ready0", data_ready[0], 0);
            chk("req_data_ready1", data_ready[1], 0);
            if (req_valid[o]) begin
                chk("req_rw", mem_req_rw, req_rw[o]);
                chk("req_addr", mem_req_addr, req_addr[o]);
                chk("req_tag", mem_req_tag, {o[0], req_tag[o]});
            end
            if (!reset && req_valid[o] && mem_req_ready) begin
                m_last = o[0];
                glog.push_back(int'(mem_req_tag[4]));
                if (req_rw[o]) begin
                    for (int i = 0; i < 4; i++) begin
                        eb.push_back(wb[o][i]);
                        em.push_back(wm[o][i]);
                    end
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
        end else begin
            chk("wd_req_valid", mem_req_valid, 0);
            chk("wd_req_ready0", req_ready[0], 0);
            chk("wd_req_ready1", req_ready[1], 0);
            chk("wd_data_valid", mem_req_data_valid, data_valid[o]);
            chk("wd_data_ready_owner", data_ready[o], mem_req_data_ready);
            chk("wd_data_ready_other", data_ready[1-o], 0);
            if (data_valid[o] && eb.size() > 0) begin
                chk("wd_bits", mem_req_data_bits, eb[0]);
                chk("wd_mask", mem_req_data_mask, em[0]);
            end
            if (!reset && data_valid[o] && mem_req_data_ready && eb.size() > 0) begin
                blog.push_back(mem_req_data_bits);
                void'(eb.pop_front());
                void'(em.pop_front());
                if (eb.size() == 0) m_phase = 0;
            end
        end
        rst_prev = reset;
    end

    // One requester transaction; beats are sequential values from base, or random.
    task automatic do_txn(input int p, input bit rw, input logic [27:0] addr,
                          input logic [3:0] tag, input logic [127:0] base, input bit gaps);
        int n;
        for (int i = 0; i < 4; i++) begin
            wb[p][i] = (base != 0) ? base + 128'(i) : {$urandom, $urandom, $urandom, $urandom};
            wm[p][i] = 16'($urandom);
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b1; req_rw[p] = rw; req_addr[p] = addr; req_tag[p] = tag;
        n = 0;
        @(negedge clk);
        while (req_ready[p] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) chk("req_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        if (rw) begin
            for (int b = 0; b < 4; b++) begin
                if (gaps) while (($urandom % 3) == 0) begin @(posedge clk); #1; end
                data_valid[p] = 1'b1; data_bits[p] = wb[p][b]; data_mask[p] = wm[p][b];
                n = 0;
                @(negedge clk);
                while (data_ready[p] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
                if (n >= LIMIT) chk("data_timeout", 0, 1);
                @(posedge clk); #1;
                data_valid[p] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin req_valid[p] = 1'b0; data_valid[p] = 1'b0; end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 0; req_rw[p] = 0; req_addr[p] = 0; req_tag[p] = 0;
            data_valid[p] = 0; data_bits[p] = 0; data_mask[p] = 0;
        end
        mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 0; mem_resp_tag = 0; mem_resp_data = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_data_valid", mem_req_data_valid, 0);
        chk("rst_ready0", req_ready[0], 0);
        chk("rst_ready1", req_ready[1], 0);

        // Single p0 read with a routed response
        mem_req_ready = 1;
        @(posedge clk); #1;
        req_valid[0] = 1; req_rw[0] = 0; req_addr[0] = 28'h0000123; req_tag[0] = 4'h3;
        @(negedge clk);
        chk("t1_idle_valid", mem_req_valid, 0);
        @(negedge clk);
        chk("t1_req_valid", mem_req_valid, 1);
        chk("t1_tag", mem_req_tag, 5'h03);
        chk("t1_rw", mem_req_rw, 0);
        chk("t1_addr", mem_req_addr, 28'h0000123);
        chk("t1_ready", req_ready[0], 1);
        @(posedge clk); #1;
        req_valid[0] = 0;
        mem_resp_valid = 1; mem_resp_tag = 5'h03; mem_resp_data = 128'hCAFE;
        @(negedge clk);
        chk("t1_resp_valid0", resp_valid[0], 1);
        chk("t1_resp_tag0", resp_tag[0], 4'h3);
        chk("t1_resp_valid1", resp_valid[1], 0);
        chk("t1_resp_data0", resp_data[0], 128'hCAFE);
        @(posedge clk); #1;
        mem_resp_valid = 0;

        // Both ports reading continuously after reset alternate, p0 first
        do_reset();
        glog.delete();
        fork
            begin repeat (3) do_txn(0, 0, 28'($urandom), 4'($urandom), 0, 0); end
            begin repeat (3) do_txn(1, 0, 28'($urandom), 4'($urandom), 0, 0); end
        join
        chk("t2_log_size", glog.size(), 6);
        if (glog.size() >= 4) begin
            chk("t2_grant0", glog[0], 0);
            chk("t2_grant1", glog[1], 1);
            chk("t2_grant2", glog[2], 0);
            chk("t2_grant3", glog[3], 1);
        end

        // p1 write with toggling data ready; p0 arrives mid-write and waits
        glog.delete(); blog.delete();
        mem_req_data_ready = 1; tog_dr = 1;
        fork
            do_txn(1, 1, 28'h0ABCDE0, 4'h5, 128'hA, 0);
            begin repeat (3) @(posedge clk); do_txn(0, 0, 28'h0000055, 4'h1, 0, 0); end
        join
        tog_dr = 0;
        chk("t3_log_size", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t3_first_p1", glog[0], 1);
            chk("t3_then_p0", glog[1], 0);
        end
        chk("t3_beats", blog.size(), 4);
        if (blog.size() == 4) begin
            chk("t3_beat0", blog[0], 128'hA);
            chk("t3_beat1", blog[1], 128'hB);
            chk("t3_beat2", blog[2], 128'hC);
            chk("t3_beat3", blog[3], 128'hD);
        end

        // Stalled GRANT: request held, fields stable, a competing p1 waits
        mem_req_ready = 0;
        @(posedge clk); #1;
        req_valid[0] = 1; req_rw[0] = 0; req_addr[0] = 28'h0000777; req_tag[0] = 4'h6;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", mem_req_valid, 1);
            chk("t4_stall_addr", mem_req_addr, 28'h0000777);
            chk("t4_stall_tag", mem_req_tag, 5'h06);
            if (i == 0) begin
                @(posedge clk); #1;
                req_valid[1] = 1; req_rw[1] = 0; req_addr[1] = 28'h0000888; req_tag[1] = 4'h7;
            end
        end
        @(posedge clk); #1;
        mem_req_ready = 1;
        @(negedge clk);
        chk("t4_release", req_ready[0], 1);
        @(posedge clk); #1;
        req_valid[0] = 0;
        n = 0;
        @(negedge clk);
        while (req_ready[1] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        chk("t4_p1_served", mem_req_tag, 5'h17);
        @(posedge clk); #1;
        req_valid[1] = 0;

        // Reset during beat 2 of a p1 write abandons it
        mem_req_data_ready = 1;
        for (int i = 0; i < 4; i++) begin wb[1][i] = 128'h100 + 128'(i); wm[1][i] = 16'hFFFF; end
        @(posedge clk); #1;
        req_valid[1] = 1; req_rw[1] = 1; req_addr[1] = 28'h0001234; req_tag[1] = 4'h2;
        n = 0;
        @(negedge clk);
        while (req_ready[1] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid[1] = 0;
        data_valid[1] = 1; data_bits[1] = wb[1][0]; data_mask[1] = wm[1][0];
        @(negedge clk);
        @(posedge clk); #1; data_bits[1] = wb[1][1];
        @(negedge clk);
        @(posedge clk); #1; data_bits[1] = wb[1][2]; reset = 1;
        @(negedge clk);
        chk("t5_beat2_offered", mem_req_data_bits, 128'h102);
        @(posedge clk); #1; reset = 0;
        @(negedge clk);
        chk("t5_no_residual", mem_req_data_valid, 0);
        chk("t5_data_ready1", data_ready[1], 0);
        chk("t5_req_valid", mem_req_valid, 0);
        @(posedge clk); #1; data_valid[1] = 0;
        glog.delete();
        fork
            do_txn(0, 0, 28'h0000042, 4'h4, 0, 0);
            do_txn(1, 0, 28'h0000043, 4'h4, 0, 0);
        join
        chk("t5_p0_wins", (glog.size() > 0) ? glog[0] : -1, 0);

        // Responses arriving during a p1 write
        blog.delete();
        fork
            do_txn(1, 1, 28'h0002000, 4'h9, 128'h200, 1);
            begin
                repeat (4) @(posedge clk);
                #1; mem_resp_valid = 1; mem_resp_tag = 5'h11; mem_resp_data = 128'h55;
                @(negedge clk);
                chk("t6_r1_valid1", resp_valid[1], 1);
                chk("t6_r1_tag1", resp_tag[1], 4'h1);
                chk("t6_r1_valid0", resp_valid[0], 0);
                @(posedge clk); #1; mem_resp_tag = 5'h02;
                @(negedge clk);
                chk("t6_r2_valid0", resp_valid[0], 1);
                chk("t6_r2_tag0", resp_tag[0], 4'h2);
                chk("t6_r2_valid1", resp_valid[1], 0);
                @(posedge clk); #1; mem_resp_valid = 0;
            end
        join
        chk("t6_beats", blog.size(), 4);
        if (blog.size() == 4) chk("t6_last_beat", blog[3], 128'h203);

        // Randomized traffic on both ports with random memory readiness
        rand_mem = 1; rand_resp = 1;
        fork
            begin
                repeat (40) begin
                    repeat ($urandom % 3) @(posedge clk);
                    do_txn(0, 1'($urandom), 28'($urandom), 4'($urandom), 0, 1);
                end
            end
            begin
                repeat (40) begin
                    repeat ($urandom % 3) @(posedge clk);
                    do_txn(1, 1'($urandom), 28'($urandom), 4'($urandom), 0, 1);
                end
            end
        join
        rand_mem = 0; rand_resp = 0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
